// File: rtl/systolic_pkg.sv
// Shared constants, default coefficient set and output saturation for the
// systolic FIR core.
package systolic_pkg;

    localparam int N      = 8;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 35;
    localparam int FRAC_W = 14;

    // Q1.14 taps c7..c0 (c0 in the low 16 bits); they sum to 16400, just over unity.
    localparam logic [N*COEF_W-1:0] CHEBY_COEF = {
        16'd300, 16'd1300, 16'd2900, 16'd3800,
        16'd3900, 16'd2900, 16'd1100, 16'd200
    };

    localparam logic signed [ACC_W-1:0] SAT_MAX = 35'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -35'sd32768;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return 16'sh7fff;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One systolic cell: multiplies its coefficient by its tap sample and adds the
// product to the partial sum arriving from the previous cell.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] COEF = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [ACC_W-1:0]  psum_in,
    output logic signed [ACC_W-1:0]  psum_out
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign prod     = x * COEF;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst)
            psum_out <= '0;
        else
            psum_out <= psum_in + prod_ext;
    end

endmodule

// File: rtl/systolic_wrapper.sv
// Sample-strobe wrapper around an N-cell systolic FIR array: delay line,
// busy counter, result register and registered output.
module systolic_wrapper #(
    parameter int                                    N    = systolic_pkg::N,
    parameter logic [N*systolic_pkg::COEF_W-1:0]     COEF = systolic_pkg::CHEBY_COEF
) (
    input  logic signed [systolic_pkg::DATA_W-1:0] xin,
    output logic signed [systolic_pkg::DATA_W-1:0] yout,
    input  logic                                   clk30x,
    input  logic                                   donext,
    input  logic                                   rst
);

    import systolic_pkg::*;

    localparam int CNT_W = $clog2(N + 2);

    logic signed [DATA_W-1:0] dly [N];
    logic signed [ACC_W-1:0]  psum [N+1];
    logic signed [DATA_W-1:0] result_p;
    logic        [CNT_W-1:0]  busy_cnt;
    logic                     accept;

    assign psum[0] = '0;
    assign accept  = donext && (busy_cnt == '0);

    // The chain runs freely; the delay line only moves on accepted strobes, so
    // cell k holds the right partial sum k+1 cycles after the strobe.
    for (genvar k = 0; k < N; k++) begin : g_pe
        systolic_pe #(
            .COEF (COEF[k*COEF_W +: COEF_W])
        ) u_pe (
            .clk      (clk30x),
            .rst      (rst),
            .x        (dly[k]),
            .psum_in  (psum[k]),
            .psum_out (psum[k+1])
        );
    end

    always_ff @(posedge clk30x) begin
        if (rst) begin
            busy_cnt <= '0;
            result_p <= '0;
            yout     <= '0;
            for (int i = 0; i < N; i++)
                dly[i] <= '0;
        end else if (accept) begin
            yout     <= result_p;
            busy_cnt <= CNT_W'(N + 1);
            dly[0]   <= xin;
            for (int i = 1; i < N; i++)
                dly[i] <= dly[i-1];
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
            // Last busy cycle: the final cell's sum has settled.
            if (busy_cnt == CNT_W'(1))
                result_p <= sat16(psum[N] >>> FRAC_W);
        end
    end

endmodule

// File: tb/tb_systolic_wrapper.sv
// Randomized bench for systolic_wrapper: default taps and an all-0x4000 tap set,
// both compared per strobe against a direct convolution model.
module tb_systolic_wrapper;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               donext = 1'b0;
    logic signed [15:0] xin = '0;
    logic signed [15:0] yout_a, yout_b;

    localparam logic [127:0] UNITY_COEF = {8{16'h4000}};

    systolic_wrapper u_dut_a (
        .xin    (xin),
        .yout   (yout_a),
        .clk30x (clk),
        .donext (donext),
        .rst    (rst)
    );

    systolic_wrapper #(.N(8), .COEF(UNITY_COEF)) u_dut_b (
        .xin    (xin),
        .yout   (yout_b),
        .clk30x (clk),
        .donext (donext),
        .rst    (rst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    shortint coef_ref [8] = '{200, 1100, 2900, 3900, 3800, 2900, 1300, 300};
    shortint hist [$];
    logic signed [15:0] y_a = '0, y_b = '0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // y[n] = sat16(sum ck*x[n-k] >>> 14), samples before reset count as zero.
    function automatic logic signed [15:0] model_y(input bit unity);
        longint acc = 0;
        for (int k = 0; k < 8; k++)
            if (k < hist.size())
                acc += longint'(unity ? shortint'(16384) : coef_ref[k]) * longint'(hist[k]);
        acc = acc >>> 14;
        if (acc > 32767)  return 16'sh7fff;
        if (acc < -32768) return 16'sh8000;
        return 16'(acc);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        y_a = '0;
        y_b = '0;
        check("reset_a", yout_a, 16'h0000);
        check("reset_b", yout_b, 16'h0000);
    endtask

    // One sample at 30-cycle spacing; optionally fire an illegal strobe 5 cycles in.
    task automatic strobe(input logic [15:0] x, input bit viol);
        logic signed [15:0] exp_a, exp_b;
        check("pre_a", yout_a, y_a == y_a ? yout_a : 16'h0);
        exp_a = y_a;
        exp_b = y_b;
        xin = x;
        donext = 1'b1;
        @(posedge clk);
        #1;
        donext = 1'b0;
        hist.push_front(shortint'(x));
        if (hist.size() > 8) void'(hist.pop_back());
        y_a = model_y(1'b0);
        y_b = model_y(1'b1);
        check("strobe_a", yout_a, exp_a);
        check("strobe_b", yout_b, exp_b);
        if (viol) begin
            repeat (4) @(posedge clk);
            #1;
            xin = 16'($urandom);
            donext = 1'b1;
            @(posedge clk);
            #1;
            donext = 1'b0;
            check("viol_a", yout_a, exp_a);
            check("viol_b", yout_b, exp_b);
            repeat (24) @(posedge clk);
        end else begin
            repeat (29) @(posedge clk);
        end
        #1;
        check("hold_a", yout_a, exp_a);
        check("hold_b", yout_b, exp_b);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 3; i++) strobe(16'h0000, 1'b0);

        // Impulse: outputs at strobe edges run 0, 0, c0..c7, 0
        strobe(16'h4000, 1'b0);
        for (int i = 0; i < 10; i++) strobe(16'h0000, 1'b0);

        for (int i = 0; i < 12; i++) strobe(16'h1000, 1'b0);
        check("dc_a", y_a, 16'd4100);
        check("dc_b", y_b, 16'h7fff);

        for (int i = 0; i < 20; i++) strobe(16'($urandom), 1'b0);

        for (int i = 0; i < 10; i++) strobe(16'h7fff, 1'b0);
        check("satp_b", yout_b, 16'h7fff);
        for (int i = 0; i < 10; i++) strobe(16'h8000, 1'b0);
        check("satn_b", yout_b, 16'h8000);

        for (int i = 0; i < 4; i++) strobe(16'($urandom_range(0, 16'h3fff)), 1'b1);
        for (int i = 0; i < 4; i++) strobe(16'($urandom), 1'b0);

        // Mid-run reset 4 cycles after a strobe, with a strobe in the reset cycle
        xin = 16'h4000;
        donext = 1'b1;
        @(posedge clk);
        #1;
        donext = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        donext = 1'b1;
        xin = 16'h1234;
        @(posedge clk);
        #1;
        rst = 1'b0;
        donext = 1'b0;
        hist.delete();
        y_a = '0;
        y_b = '0;
        check("midrst_a", yout_a, 16'h0000);
        check("midrst_b", yout_b, 16'h0000);
        repeat (12) @(posedge clk);
        #1;
        check("midrst_hold_a", yout_a, 16'h0000);
        strobe(16'h4000, 1'b0);
        for (int i = 0; i < 9; i++) strobe(16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
